seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, giving clocks per digit slot; legal range 2..65535.
REQ-002 SHALL have parameter LZB, default 1, enabling leading-zero blanking when 1.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-005 in_valid  input  1  producer offers a new 16-bit value.
REQ-006 in_data  input  16  value to display as 4 hex digits; digit k = in_data[4k+3:4k].
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 off  input  1  synchronous request to stop scanning and blank the display.
REQ-009 seg  output  7  shared segment bus, active-high, seg[6]=a ... seg[0]=g.
REQ-010 an  output  4  digit enables, active-high, at most one bit set.
REQ-011 frame_done  output  1  one-cycle pulse at the last cycle of each full 4-digit frame.

Function
REQ-012 SHALL implement two states: IDLE and SCAN.
REQ-013 SHALL hold registers: val[15:0], slot counter cnt (0..DIV-1), digit index d (0..3).
REQ-014 IDLE: an=0, seg=0, frame_done=0, in_ready=1.
REQ-015 IDLE -> SCAN on transfer (in_valid && in_ready && !off); val<=in_data, d<=0, cnt<=0.
REQ-016 SCAN: cnt increments each cycle; at cnt==DIV-1 cnt wraps to 0 and d advances, 3 wrapping to 0.
REQ-017 SCAN: an = one-hot bit d, except an=0 in the cycle cnt==0 (anti-ghosting dead cycle).
REQ-018 SCAN: seg = hex decode of digit d of val whenever an!=0; seg=0 when an==0.
REQ-019 Hex decode (abcdefg): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111.
REQ-020 LZB=1: digit k>0 is blanked (seg=0, an still driven) when val[15:4k] is all zero; digit 0 never blanked.
REQ-021 SCAN: in_ready=1 only when d==3 && cnt==DIV-1; otherwise 0.
REQ-022 SCAN: frame_done=1 exactly when d==3 && cnt==DIV-1, independent of in_valid.
REQ-023 Transfer in SCAN loads val at the frame boundary; the next frame (d=0) shows the new value; no mid-frame value change.
REQ-024 in_valid without in_ready SHALL be ignored; producer holds in_valid/in_data until transfer.
REQ-025 off=1 in any state: next state IDLE, cnt/d cleared; off has priority over a simultaneous transfer (no load, in_ready still reflects state but transfer is not taken).
REQ-026 off=1 in IDLE keeps IDLE; val retained but not displayed.
REQ-027 seg, an, in_ready, frame_done SHALL be decoded only from registered state (no combinational path from in_valid/in_data/off to outputs).
REQ-028 Frame period SHALL be exactly 4*DIV cycles with no gaps between frames.

Reset
REQ-029 rst=0 SHALL asynchronously set state=IDLE, val=0, cnt=0, d=0; hence an=0, seg=0, frame_done=0, in_ready=1.
REQ-030 Reset asserted mid-frame SHALL blank outputs immediately without waiting for a clock; release resumes in IDLE.
REQ-031 First rising edge after rst returns high SHALL be a normal functional edge.

Verification (DIV=4, LZB=1)
REQ-032 Reset, then in_valid=1, in_data=16'h12AF one cycle -> next cycle SCAN, cnt=0: an=0000, seg=0; cycles 1-3: an=0001, seg=1000111 (F).
REQ-033 Same value over one frame -> digits show F, A, 2, 1 on an=0001/0010/0100/1000; frame_done pulses once every 16 cycles; in_ready high only on that cycle.
REQ-034 Load 16'h0007 -> digit 0 seg=1110000; digits 1-3 an driven with seg=0; load 16'h0000 -> digit 0 shows 1111110, others blank.
REQ-035 Hold in_valid=1 with 16'h5555 from mid-frame -> accepted only on frame_done cycle; prior value displayed until then; next frame shows 5 on all digits.
REQ-036 off=1 coincident with frame_done and in_valid=1 -> IDLE next cycle, an=0, val unchanged (new data not loaded).
REQ-037 rst pulsed low mid-digit-2 without clock edge -> an=0, seg=0, in_ready=1 immediately; after release, idle until next transfer.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- multiplexed 4-digit 7-segment scan controller.
//
// A 16-bit value is taken through a valid/ready handshake and shown as
// four hex digits, one digit slot of DIV clocks at a time. The first clock
// of every slot is a dead cycle with all anodes off to avoid ghosting.
// A new value is only taken at a frame boundary, so a frame never mixes
// two values.
//
// Parameters
//   DIV  clocks per digit slot (2..65535)
//   LZB  1 = blank leading zero digits (digit 0 is never blanked)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   in_valid    producer offers in_data
//   in_data     16-bit value, digit k = in_data[4k+3:4k]
//   in_ready    block accepts in_data this cycle
//   off         stop scanning and blank the display (wins over a transfer)
//   seg         segment bus, active-high, seg[6]=a .. seg[0]=g
//   an          digit enables, active-high, at most one bit set
//   frame_done  one-cycle pulse on the last cycle of each 4-digit frame
module seg_scan_ctrl #(
  parameter int DIV = 4,
  parameter bit LZB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        off,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int             CW      = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state;
  logic [15:0]   val;
  logic [CW-1:0] cnt;
  logic [1:0]    d;

  logic          last_cycle;
  logic          take;
  logic [3:0]    digit;
  logic          blank;

  // Hex to abcdefg segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1111110;
      4'h1: hex_to_seg = 7'b0110000;
      4'h2: hex_to_seg = 7'b1101101;
      4'h3: hex_to_seg = 7'b1111001;
      4'h4: hex_to_seg = 7'b0110011;
      4'h5: hex_to_seg = 7'b1011011;
      4'h6: hex_to_seg = 7'b1011111;
      4'h7: hex_to_seg = 7'b1110000;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1111011;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b0011111;
      4'hC: hex_to_seg = 7'b1001110;
      4'hD: hex_to_seg = 7'b0111101;
      4'hE: hex_to_seg = 7'b1001111;
      default: hex_to_seg = 7'b1000111;
    endcase
  endfunction

  // Last cycle of a frame: the only SCAN cycle where a new value may enter.
  assign last_cycle = (state == SCAN) && (d == 2'd3) && (cnt == CNT_MAX);
  assign in_ready   = (state == IDLE) || last_cycle;
  assign frame_done = last_cycle;
  assign take       = in_valid && in_ready && !off;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would create
  // order-dependent simulation and mismatch synthesis.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      val   <= '0;
      cnt   <= '0;
      d     <= '0;
    end else if (off) begin
      // off beats a simultaneous transfer; val is kept but not shown.
      state <= IDLE;
      cnt   <= '0;
      d     <= '0;
    end else if (take) begin
      // In SCAN this coincides with the natural wrap, so frames stay gapless.
      state <= SCAN;
      val   <= in_data;
      cnt   <= '0;
      d     <= '0;
    end else if (state == SCAN) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        d   <= d + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Outputs are decoded from registers only, so the async reset blanks them
  // at once and no input reaches an output combinationally.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    digit = '0;
    blank = 1'b0;
    an    = '0;
    seg   = '0;
    case (d)
      2'd0: digit = val[3:0];
      2'd1: digit = val[7:4];
      2'd2: digit = val[11:8];
      default: digit = val[15:12];
    endcase
    if (LZB) begin
      case (d)
        2'd1: blank = (val[15:4]  == 12'h000);
        2'd2: blank = (val[15:8]  == 8'h00);
        2'd3: blank = (val[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
    if ((state == SCAN) && (cnt != '0)) begin
      an = 4'b0001 << d;
      if (!blank) seg = hex_to_seg(digit);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with DIV=4, LZB=1.
module tb_seg_scan_ctrl;

  localparam logic [6:0] S_0 = 7'b1111110;
  localparam logic [6:0] S_1 = 7'b0110000;
  localparam logic [6:0] S_2 = 7'b1101101;
  localparam logic [6:0] S_5 = 7'b1011011;
  localparam logic [6:0] S_7 = 7'b1110000;
  localparam logic [6:0] S_A = 7'b1110111;
  localparam logic [6:0] S_C = 7'b1001110;
  localparam logic [6:0] S_F = 7'b1000111;
  localparam logic [6:0] S_X = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        off;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(.DIV(4), .LZB(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .off        (off),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_an,
                           input logic [6:0] exp_seg, input logic exp_fd,
                           input logic exp_rdy);
    n_assert++;
    assert (an === exp_an) else begin
      n_fail++;
      $error("FAIL %s an=%b expected %b", tag, an, exp_an);
    end
    n_assert++;
    assert (seg === exp_seg) else begin
      n_fail++;
      $error("FAIL %s seg=%b expected %b", tag, seg, exp_seg);
    end
    n_assert++;
    assert (frame_done === exp_fd) else begin
      n_fail++;
      $error("FAIL %s frame_done=%b expected %b", tag, frame_done, exp_fd);
    end
    n_assert++;
    assert (in_ready === exp_rdy) else begin
      n_fail++;
      $error("FAIL %s in_ready=%b expected %b", tag, in_ready, exp_rdy);
    end
  endtask

  // Checks one whole frame starting at its dead cycle (d=0, cnt=0) and
  // returns while sampling its last cycle, so the caller can set inputs
  // that act on the frame boundary edge.
  task automatic check_frame(input string tag, input logic [6:0] s0,
                             input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 16; i++) begin
      int dd = i / 4;
      int cc = i % 4;
      logic [3:0] ea = (cc == 0) ? 4'b0000 : 4'(1 << dd);
      logic [6:0] es = (cc == 0) ? S_X : s[dd];
      check_out($sformatf("%s[d%0d c%0d]", tag, dd, cc), ea, es,
                i == 15, i == 15);
      if (i < 15) step();
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    off      = 1'b0;
    #3;
    check_out("reset", 4'b0000, S_X, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Load 12AF from IDLE: F, A, 2, 1 across two consecutive frames.
    in_valid = 1'b1;
    in_data  = 16'h12AF;
    step();
    in_valid = 1'b0;
    check_frame("f12af_a", S_F, S_A, S_2, S_1);
    step();
    check_frame("f12af_b", S_F, S_A, S_2, S_1);

    // Leading-zero blanking: anodes still driven, segments dark.
    in_valid = 1'b1;
    in_data  = 16'h0007;
    step();
    in_valid = 1'b0;
    check_frame("f0007", S_7, S_X, S_X, S_X);
    in_valid = 1'b1;
    in_data  = 16'h0000;
    step();
    in_valid = 1'b0;
    check_frame("f0000", S_0, S_X, S_X, S_X);

    // Held valid across a frame is only taken at the boundary.
    step();
    in_valid = 1'b1;
    in_data  = 16'h5555;
    check_frame("hold_old", S_0, S_X, S_X, S_X);
    step();
    in_valid = 1'b0;
    check_frame("f5555", S_5, S_5, S_5, S_5);

    // off with frame_done and valid: goes IDLE, no load.
    off      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    step();
    check_out("off_bound", 4'b0000, S_X, 1'b0, 1'b1);
    step();
    check_out("off_idle_hold", 4'b0000, S_X, 1'b0, 1'b1);
    off      = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    check_out("idle_stays", 4'b0000, S_X, 1'b0, 1'b1);

    // Digit 0 zero is never blanked, inner nonzero digit shown.
    in_valid = 1'b1;
    in_data  = 16'h00C0;
    step();
    in_valid = 1'b0;
    check_frame("f00c0", S_0, S_C, S_X, S_X);
    step();
    step();
    step();
    check_out("mid_scan", 4'b0001, S_0, 1'b0, 1'b0);
    off = 1'b1;
    step();
    off = 1'b0;
    check_out("off_mid", 4'b0000, S_X, 1'b0, 1'b1);

    // Async reset mid digit 2, between clock edges.
    in_valid = 1'b1;
    in_data  = 16'h12AF;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_out("pre_rst_d2", 4'b0100, S_2, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, S_X, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    step();
    step();
    check_out("post_rst_idle", 4'b0000, S_X, 1'b0, 1'b1);

    // First edges after release are ordinary: a load works normally.
    in_valid = 1'b1;
    in_data  = 16'h000A;
    step();
    in_valid = 1'b0;
    check_out("reload_dead", 4'b0000, S_X, 1'b0, 1'b0);
    step();
    check_out("reload_d0", 4'b0001, S_A, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  // Bound on total run time so the bench always terminates.
  initial begin
    #50000;
    $display("FAIL timeout reached=1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
